// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares one single-port synchronous ROM (1-cycle read latency) between the
// core's instruction-fetch port and its data-load port.
//
// Each cycle at most one requester is granted. The grant is combinational, and
// so are the ROM enable and word address, so the ROM samples the winner's
// address on the grant edge. One cycle later a registered tag routes the ROM
// data back to the winner and pulses that port's rvalid for one cycle. Each
// port keeps its last read data in a hold register, so its rdata stays stable
// between responses.
//
// Addresses beyond the ROM are still granted and still use a ROM cycle. Their
// data is returned as zero and the port's err flag is raised. A saturating
// counter records every cycle in which both ports request.
//
// Parameters
//   MEM_DEPTH   ROM depth in 32-bit words (power of two)
//   FIXED_PRIO  0: round-robin on contention, 1: instruction port always wins
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   insn_req_i       fetch request
//   insn_addr_i      fetch byte address
//   insn_gnt_o       fetch accepted this cycle (combinational)
//   insn_rvalid_o    fetch data valid
//   insn_rdata_o     fetch read data (held between responses)
//   insn_err_o       fetch address out of range (valid with rvalid)
//   mem_req_i        load request
//   mem_addr_i       load byte address
//   mem_gnt_o        load accepted this cycle (combinational)
//   mem_rvalid_o     load data valid
//   mem_rdata_o      load read data (held between responses)
//   mem_err_o        load address out of range (valid with rvalid)
//   rom_en_o         ROM read enable
//   rom_addr_o       ROM word address
//   rom_rdata_i      ROM data, valid one cycle after rom_en_o
//   conflict_cnt_o   saturating count of cycles with both ports requesting
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
    parameter int MEM_DEPTH  = 256,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         insn_req_i,
    input  logic [31:0]                  insn_addr_i,
    output logic                         insn_gnt_o,
    output logic                         insn_rvalid_o,
    output logic [31:0]                  insn_rdata_o,
    output logic                         insn_err_o,

    input  logic                         mem_req_i,
    input  logic [31:0]                  mem_addr_i,
    output logic                         mem_gnt_o,
    output logic                         mem_rvalid_o,
    output logic [31:0]                  mem_rdata_o,
    output logic                         mem_err_o,

    output logic                         rom_en_o,
    output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
    input  logic [31:0]                  rom_rdata_i,

    output logic [15:0]                  conflict_cnt_o
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    // True when any byte-address bit above the ROM's word range is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return ((addr >> (ADDR_W + 2)) != 32'd0);
    endfunction

    // Word index inside the ROM. The two byte-offset bits are dropped, so
    // misaligned addresses simply read the containing word.
    function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
        return addr[ADDR_W+1:2];
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic              both_req_s;
    logic              insn_win_s;
    logic              mem_win_s;
    logic              any_gnt_s;
    logic [31:0]       win_addr_s;
    logic              win_err_s;
    logic [ADDR_W-1:0] rom_addr_s;
    logic [31:0]       insn_rdata_s;
    logic [31:0]       mem_rdata_s;

    logic              prio_insn_r;     // 1: insn wins the next contended cycle
    logic [ADDR_W-1:0] last_addr_r;     // ROM address to keep driving while idle
    logic              insn_rvalid_r;
    logic              mem_rvalid_r;
    logic              insn_err_r;
    logic              mem_err_r;
    logic [31:0]       insn_hold_r;
    logic [31:0]       mem_hold_r;
    logic [15:0]       conflict_cnt_r;

    assign both_req_s = insn_req_i & mem_req_i;

    // Arbitration. No grant is issued while reset is held, so a reset
    // cannot start a read whose response would appear after reset releases.
    always_comb begin
        insn_win_s = 1'b0;
        mem_win_s  = 1'b0;
        if (rst_i) begin
            insn_win_s = 1'b0;
            mem_win_s  = 1'b0;
        end else if (both_req_s) begin
            if ((FIXED_PRIO == 1'b1) || prio_insn_r) begin
                insn_win_s = 1'b1;
            end else begin
                mem_win_s  = 1'b1;
            end
        end else if (insn_req_i) begin
            insn_win_s = 1'b1;
        end else if (mem_req_i) begin
            mem_win_s  = 1'b1;
        end else begin
            insn_win_s = 1'b0;
            mem_win_s  = 1'b0;
        end
    end

    assign any_gnt_s  = insn_win_s | mem_win_s;
    assign win_addr_s = insn_win_s ? insn_addr_i : mem_addr_i;
    assign win_err_s  = addr_out_of_range(win_addr_s);

    // ROM address: the winner's word index on a grant, the previous address
    // while idle, and zero while reset is held.
    always_comb begin
        rom_addr_s = last_addr_r;
        if (rst_i) begin
            rom_addr_s = {ADDR_W{1'b0}};
        end else if (any_gnt_s) begin
            rom_addr_s = word_index(win_addr_s);
        end else begin
            rom_addr_s = last_addr_r;
        end
    end

    // Read data: live masked ROM data in the response cycle, otherwise the
    // port's held copy of its last response.
    assign insn_rdata_s = insn_rvalid_r ? (insn_err_r ? 32'h0000_0000 : rom_rdata_i)
                                        : insn_hold_r;
    assign mem_rdata_s  = mem_rvalid_r  ? (mem_err_r  ? 32'h0000_0000 : rom_rdata_i)
                                        : mem_hold_r;

    // Arbitration state: round-robin pointer and idle ROM address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_insn_r <= 1'b1;
            last_addr_r <= {ADDR_W{1'b0}};
        end else begin
            // The pointer moves only on contention; after a contended grant
            // the loser gets priority next time.
            if (both_req_s && any_gnt_s) begin
                prio_insn_r <= mem_win_s;
            end
            if (any_gnt_s) begin
                last_addr_r <= rom_addr_s;
            end
        end
    end

    // Response tag: which port owns the ROM data next cycle, and its err flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            insn_rvalid_r <= 1'b0;
            mem_rvalid_r  <= 1'b0;
            insn_err_r    <= 1'b0;
            mem_err_r     <= 1'b0;
        end else begin
            insn_rvalid_r <= insn_win_s;
            mem_rvalid_r  <= mem_win_s;
            // A port's err flag changes only when that port is granted.
            if (insn_win_s) begin
                insn_err_r <= win_err_s;
            end
            if (mem_win_s) begin
                mem_err_r <= win_err_s;
            end
        end
    end

    // Per-port hold registers capture each response as it is delivered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            insn_hold_r <= 32'h0000_0000;
            mem_hold_r  <= 32'h0000_0000;
        end else begin
            if (insn_rvalid_r) begin
                insn_hold_r <= insn_rdata_s;
            end
            if (mem_rvalid_r) begin
                mem_hold_r <= mem_rdata_s;
            end
        end
    end

    // Saturating contention counter. Only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_r <= 16'h0000;
        end else if (both_req_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign insn_gnt_o     = insn_win_s;
    assign mem_gnt_o      = mem_win_s;
    assign rom_en_o       = any_gnt_s;
    assign rom_addr_o     = rom_addr_s;
    assign insn_rvalid_o  = insn_rvalid_r;
    assign mem_rvalid_o   = mem_rvalid_r;
    assign insn_rdata_o   = insn_rdata_s;
    assign mem_rdata_o    = mem_rdata_s;
    assign insn_err_o     = insn_err_r;
    assign mem_err_o      = mem_err_r;
    assign conflict_cnt_o = conflict_cnt_r;

endmodule
